// File: rtl/qerv_wb_arbiter.sv
// Two-master Wishbone arbiter merging qerv ibus/dbus onto one classic port.
// Optional slave timeout with sticky error: define QERV_ARB_TIMEOUT_EN.
module qerv_wb_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  input  logic [31:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_cyc,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  output logic        o_err
);

  typedef enum logic [1:0] {
    IDLE,
    IBUS,
    DBUS
  } state_t;

  state_t r_state;
  logic   r_last;
  logic   w_to;
  logic   w_ack;
  logic   w_drop;
  logic   w_ib;
  logic   w_db;

  assign w_ib = (r_state == IBUS);
  assign w_db = (r_state == DBUS);

`ifdef QERV_ARB_TIMEOUT_EN
  logic [15:0] r_cnt;
  logic        r_err;

  // Fires on the TIMEOUT-th granted cycle unless the slave acks then
  assign w_to = (r_state != IDLE) & ~i_wb_ack &
                (r_cnt == 16'(TIMEOUT - 1));
  assign o_err = r_err;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_cnt <= 16'd0;
      r_err <= 1'b0;
    end else begin
      if (r_state == IDLE)
        r_cnt <= 16'd0;
      else if (!i_wb_ack)
        r_cnt <= r_cnt + 16'd1;
      if (w_to)
        r_err <= 1'b1;
    end
  end
`else
  logic w_unused_timeout;

  assign w_unused_timeout = (TIMEOUT == 0);
  assign w_to  = 1'b0;
  assign o_err = 1'b0;
`endif

  // A slave ack coinciding with reset is dropped
  assign w_ack  = (i_wb_ack | w_to) & ~i_rst;
  assign w_drop = (w_ib & ~i_ibus_cyc) | (w_db & ~i_dbus_cyc);

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_last  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (i_dbus_cyc && (!i_ibus_cyc || !r_last)) begin
            r_state <= DBUS;
            r_last  <= 1'b1;
          end else if (i_ibus_cyc) begin
            r_state <= IBUS;
            r_last  <= 1'b0;
          end
        end
        IBUS, DBUS: begin
          if (w_ack || w_drop)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_wb_cyc = w_ib | w_db;
  assign o_wb_adr = w_db ? i_dbus_adr : i_ibus_adr;
  assign o_wb_dat = i_dbus_dat;
  assign o_wb_sel = w_db ? i_dbus_sel : (w_ib ? 4'hf : 4'h0);
  assign o_wb_we  = w_db & i_dbus_we;

  assign o_ibus_ack = w_ack & w_ib;
  assign o_dbus_ack = w_ack & w_db;
  assign o_ibus_rdt = w_to ? 32'h0 : i_wb_rdt;
  assign o_dbus_rdt = w_to ? 32'h0 : i_wb_rdt;

endmodule
